ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (64x8, registered read) between two requesters.
//  Round-robin arbitration with bounded burst hold; per-requester valid/ready request channel.
//  Read responses are returned to the requester that issued the read.
//  Sits between client logic and single_port_ram; the RAM itself is instantiated outside.
// PARAMETERS
//  ADDR_W     6   RAM address width
//  DATA_W     8   RAM data width
//  MAX_BURST  4   max consecutive grants to one owner while the other requester waits (>=1)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  req_valid_i  in   2       per-requester request valid (bit n = requester n)
//  req_we_i     in   2       1 = write, 0 = read
//  req_addr_i   in   2*ADDR_W  request address, requester n at [n*ADDR_W +: ADDR_W]
//  req_wdata_i  in   2*DATA_W  write data, same packing
//  req_ready_o  out  2       one-hot grant; request accepted when valid & ready
//  rsp_valid_o  out  2       read data valid for requester n
//  rsp_rdata_o  out  DATA_W  read data (shared bus, qualified by rsp_valid_o)
//  ram_addr_o   out  ADDR_W  to RAM addr
//  ram_data_o   out  DATA_W  to RAM data
//  ram_we_o     out  1       to RAM write enable
//  ram_q_i      in   DATA_W  from RAM q (mem[addr] registered at clk edge)
// BEHAVIOUR
//  Reset: state=IDLE, last_owner=1 (requester 0 wins first), burst_cnt=0, rsp_valid_o=0;
//   while rst=1: req_ready_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0, rsp_rdata_o=0.
//  FSM states IDLE, OWN0, OWN1; grant is combinational from state + req_valid_i:
//   IDLE: grant to the requester that is valid; both valid -> the one != last_owner.
//   OWNn: n valid and (other idle or burst_cnt<MAX_BURST) -> keep n;
//         n valid, other valid, burst_cnt==MAX_BURST -> grant other;
//         n not valid -> grant other if valid, else no grant.
//   Next state = OWN<granted>, or IDLE if no grant. burst_cnt=1 on owner change,
//   +1 on repeat grant, saturates at MAX_BURST; cleared in IDLE. last_owner updates on every grant.
//  req_ready_o is one-hot or zero; never asserted for a requester whose valid is low.
//  RAM drive: granted requester's addr/wdata muxed to ram_*; ram_we_o = grant & we. No grant ->
//   ram_we_o=0, ram_addr_o/ram_data_o hold last driven values (registered copy).
//  Read latency 1: read accepted in cycle N -> rsp_valid_o[n]=1 in cycle N+1 with
//   rsp_rdata_o=ram_q_i; otherwise rsp_rdata_o=0. Writes produce no response.
//  Back-to-back: one access per cycle total; throughput 1/cycle; reads from alternating owners
//   pipeline without bubbles. Write then read same addr on consecutive cycles returns new data.
//  Reset mid-operation: pending read response is dropped (rsp_valid_o cleared asynchronously).
// CONFIGURATION
//  RAM_ARB_STATS_EN defined: adds outputs grant_cnt0_o, grant_cnt1_o (16 bits each),
//   incremented on each accepted request of that requester, saturate at 16'hFFFF, reset to 0.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  Package ram_arb_pkg: ADDR_W/DATA_W defaults, FSM state encoding (IDLE=2'd0, OWN0=2'd1,
//   OWN1=2'd2), requester index constants.
//  Sub-module ram_arb_stats (saturating grant counters), instantiated only under RAM_ARB_STATS_EN.
//  Arbiter FSM, burst counter and response pipeline stay in this module.
// TESTING
//  Bench pairs this block with single_port_ram model; clk period 10.
//  1 Req0 writes 8'h11@6'h05, next cycle reads 6'h05 -> rsp_valid_o=2'b01 one cycle later, rdata 8'h11.
//  2 Both valid from reset, reads -> grant order 0,0,0,0,1,1,1,1,0 (MAX_BURST=4); rsp follows 1 cycle later.
//  3 Req1 only, 10 reads back-to-back -> ready_o[1] high every cycle, no forced switch, 10 responses.
//  4 Req0 drops valid mid-burst while req1 valid -> grant moves to 1 the same cycle, no idle gap.
//  5 Assert rst one cycle after a read is accepted -> rsp_valid_o=0 immediately, ram_we_o=0,
//    after release first grant goes to requester 0.
//  6 RAM_ARB_STATS_EN: 3 grants req0, 5 grants req1 -> grant_cnt0_o=3, grant_cnt1_o=5; rst -> 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter.
// Holds default widths, the FSM state encoding and the requester index constants.
package ram_arb_pkg;

   localparam int ADDR_W_DEF    = 6;
   localparam int DATA_W_DEF    = 8;
   localparam int MAX_BURST_DEF = 4;

   localparam int REQ0 = 0;
   localparam int REQ1 = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   function automatic logic [1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_arb_stats.sv
// Saturating per-requester grant counters for the RAM port arbiter.
// Ports: clk, rst (async high), accept[1:0] one-hot grant, cnt0/cnt1 16-bit counts.
module ram_arb_stats
   import ram_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  accept,
   output logic [15:0] cnt0,
   output logic [15:0] cnt1
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (accept[REQ0] && cnt0 != 16'hFFFF)
            cnt0 <= cnt0 + 16'd1;
         if (accept[REQ1] && cnt1 != 16'hFFFF)
            cnt1 <= cnt1 + 16'd1;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read single-port RAM between two
// requesters, with bounded burst hold and per-requester read responses.
// Ports: clk, rst (async high); req_valid_i/req_we_i/req_addr_i/req_wdata_i and
// req_ready_o request channel; rsp_valid_o/rsp_rdata_o read responses;
// ram_addr_o/ram_data_o/ram_we_o/ram_q_i RAM side.
// Optional macro RAM_ARB_STATS_EN adds grant_cnt0_o/grant_cnt1_o counters.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid_i,
   input  logic [1:0]            req_we_i,
   input  logic [2*ADDR_W-1:0]   req_addr_i,
   input  logic [2*DATA_W-1:0]   req_wdata_i,
   output logic [1:0]            req_ready_o,
   output logic [1:0]            rsp_valid_o,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic [ADDR_W-1:0]     ram_addr_o,
   output logic [DATA_W-1:0]     ram_data_o,
   output logic                  ram_we_o,
   input  logic [DATA_W-1:0]     ram_q_i
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0]           grant_cnt0_o,
   output logic [15:0]           grant_cnt1_o
`endif
);

   localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   state_t             state;
   state_t             state_nx;
   logic               last_owner;
   logic [CNT_W-1:0]   burst_cnt;
   logic [CNT_W-1:0]   burst_nx;
   logic [1:0]         grant;
   logic               gvalid;
   logic               gidx;
   logic [ADDR_W-1:0]  addr_mux;
   logic [DATA_W-1:0]  data_mux;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;
   logic [1:0]         rsp_q;

   // Grant decision: current owner keeps the port until it drops valid or
   // exhausts its burst while the other side is waiting.
   always_comb begin
      grant = 2'b00;
      unique case (state)
         IDLE: begin
            if (&req_valid_i)
               grant = onehot(~last_owner);
            else
               grant = req_valid_i;
         end
         OWN0: begin
            if (req_valid_i[REQ0] &&
                (!req_valid_i[REQ1] || burst_cnt < BURST_MAX))
               grant = 2'b01;
            else if (req_valid_i[REQ1])
               grant = 2'b10;
         end
         OWN1: begin
            if (req_valid_i[REQ1] &&
                (!req_valid_i[REQ0] || burst_cnt < BURST_MAX))
               grant = 2'b10;
            else if (req_valid_i[REQ0])
               grant = 2'b01;
         end
         default: grant = 2'b00;
      endcase
   end

   assign gvalid = |grant;
   assign gidx   = grant[REQ1];

   always_comb begin
      state_nx = IDLE;
      burst_nx = '0;
      if (gvalid) begin
         state_nx = gidx ? OWN1 : OWN0;
         if (state_nx != state)
            burst_nx = CNT_W'(1);
         else if (burst_cnt == BURST_MAX)
            burst_nx = BURST_MAX;
         else
            burst_nx = burst_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      addr_mux = req_addr_i[REQ0*ADDR_W +: ADDR_W];
      data_mux = req_wdata_i[REQ0*DATA_W +: DATA_W];
      if (gidx) begin
         addr_mux = req_addr_i[REQ1*ADDR_W +: ADDR_W];
         data_mux = req_wdata_i[REQ1*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
         addr_q     <= '0;
         data_q     <= '0;
         rsp_q      <= 2'b00;
      end else begin
         state     <= state_nx;
         burst_cnt <= burst_nx;
         rsp_q     <= grant & ~req_we_i;
         if (gvalid) begin
            last_owner <= gidx;
            addr_q     <= addr_mux;
            data_q     <= data_mux;
         end
      end
   end

   // Outputs are forced low while reset is held, even though the
   // grant logic itself only looks at state and valids.
   assign req_ready_o = rst ? 2'b00 : grant;
   assign ram_we_o    = rst ? 1'b0 : |(grant & req_we_i);
   assign ram_addr_o  = rst ? '0 : (gvalid ? addr_mux : addr_q);
   assign ram_data_o  = rst ? '0 : (gvalid ? data_mux : data_q);
   assign rsp_valid_o = rsp_q;
   assign rsp_rdata_o = (|rsp_q) ? ram_q_i : '0;

`ifdef RAM_ARB_STATS_EN
   ram_arb_stats u_stats (
      .clk    (clk),
      .rst    (rst),
      .accept (req_ready_o),
      .cnt0   (grant_cnt0_o),
      .cnt1   (grant_cnt1_o)
   );
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a registered-read RAM model.
// Reference model tracks owner, run length, shadow memory and pending response.
module tb_ram_port_arbiter;

   localparam int AW = 6;
   localparam int DW = 8;
   localparam int MB = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     req_valid;
   logic [1:0]     req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]     req_ready;
   logic [1:0]     rsp_valid;
   logic [DW-1:0]  rsp_rdata;
   logic [AW-1:0]  ram_addr;
   logic [DW-1:0]  ram_data;
   logic           ram_we;
   logic [DW-1:0]  ram_q;
`ifdef RAM_ARB_STATS_EN
   logic [15:0]    grant_cnt0;
   logic [15:0]    grant_cnt1;
`endif

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .ram_addr_o  (ram_addr),
      .ram_data_o  (ram_data),
      .ram_we_o    (ram_we),
      .ram_q_i     (ram_q)
`ifdef RAM_ARB_STATS_EN
      ,
      .grant_cnt0_o (grant_cnt0),
      .grant_cnt1_o (grant_cnt1)
`endif
   );

   // single_port_ram stand-in: 64x8, registered read
   logic [DW-1:0] ram_mem [64];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      ram_q <= ram_mem[ram_addr];
   end

   // reference model
   logic [DW-1:0] m_mem [64];
   int            m_owner;
   int            m_last;
   int            m_run;
   logic [1:0]    m_rsp_v;
   logic [DW-1:0] m_rsp_d;
   logic [AW-1:0] m_hold_a;
   logic [DW-1:0] m_hold_d;

   int vectors = 0;
   int miscompares = 0;

   function automatic void model_reset();
      m_owner  = -1;
      m_last   = 1;
      m_run    = 0;
      m_rsp_v  = 2'b00;
      m_rsp_d  = '0;
      m_hold_a = '0;
      m_hold_d = '0;
   endfunction

   function automatic int model_pick();
      int o;
      if (m_owner < 0) begin
         if (req_valid == 2'b11) return 1 - m_last;
         if (req_valid[0]) return 0;
         if (req_valid[1]) return 1;
         return -1;
      end
      o = m_owner;
      if (req_valid[o] && (!req_valid[1-o] || m_run < MB)) return o;
      if (req_valid[1-o]) return 1 - o;
      return -1;
   endfunction

   function automatic logic [1:0] exp_grant();
      int g;
      g = model_pick();
      if (g < 0) return 2'b00;
      return (g == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [AW-1:0] addr_of(input int g);
      return (g == 1) ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
   endfunction

   function automatic logic [DW-1:0] data_of(input int g);
      return (g == 1) ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
   endfunction

   task automatic drive(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      req_valid = v;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   // advance the model across one rising edge; called at mid-cycle
   task automatic commit();
      int            g;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      g = model_pick();
      @(posedge clk);
      if (g < 0) begin
         m_rsp_v = 2'b00;
         m_rsp_d = '0;
         m_owner = -1;
         m_run   = 0;
      end else begin
         a = addr_of(g);
         d = data_of(g);
         if (req_we[g]) begin
            m_mem[a] = d;
            m_rsp_v  = 2'b00;
            m_rsp_d  = '0;
         end else begin
            m_rsp_v = (g == 1) ? 2'b10 : 2'b01;
            m_rsp_d = m_mem[a];
         end
         m_hold_a = a;
         m_hold_d = d;
         if (g == m_owner) m_run = (m_run < MB) ? m_run + 1 : MB;
         else m_run = 1;
         m_owner = g;
         m_last  = g;
      end
      #1;
   endtask

   task automatic do_reset();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(2'b11, 2'b11, 6'h2A, 6'h15, 8'h5A, 8'hA5);
      @(negedge clk);
      vectors++;
      if (req_ready !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_ready got %b want 00", req_ready);
      end
      vectors++;
      if ({ram_we, ram_addr, ram_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_ram got we=%b a=%h d=%h want 0", ram_we, ram_addr, ram_data);
      end
      vectors++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== '0) begin
         miscompares++;
         $display("FAIL reset_rsp got v=%b d=%h want 0", rsp_valid, rsp_rdata);
      end
      @(posedge clk);
      #1;
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_write_read();
      drive(2'b01, 2'b01, 6'h05, 6'h00, 8'h11, 8'h00);
      @(negedge clk);
      vectors++;
      if (req_ready !== 2'b01 || ram_we !== 1'b1 || ram_addr !== 6'h05) begin
         miscompares++;
         $display("FAIL wr_accept got rdy=%b we=%b a=%h want 01 1 05", req_ready, ram_we, ram_addr);
      end
      commit();
      drive(2'b01, 2'b00, 6'h05, 6'h00, 8'h00, 8'h00);
      @(negedge clk);
      vectors++;
      if (req_ready !== 2'b01 || ram_we !== 1'b0 || rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL rd_accept got rdy=%b we=%b rv=%b want 01 0 00", req_ready, ram_we, rsp_valid);
      end
      commit();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h11) begin
         miscompares++;
         $display("FAIL rd_rsp got v=%b d=%h want 01 11", rsp_valid, rsp_rdata);
      end
      vectors++;
      if (ram_addr !== 6'h05 || ram_we !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold got a=%h we=%b want 05 0", ram_addr, ram_we);
      end
      commit();
   endtask

   task automatic test_fairness();
      int order [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      logic [1:0] want;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i < 9) drive(2'b11, 2'b00, AW'(i), AW'(i + 16), '0, '0);
         else drive(2'b00, 2'b00, '0, '0, '0, '0);
         @(negedge clk);
         want = (i < 9) ? ((order[i] == 1) ? 2'b10 : 2'b01) : 2'b00;
         vectors++;
         if (req_ready !== want) begin
            miscompares++;
            $display("FAIL rr_order[%0d] got %b want %b", i, req_ready, want);
         end
         vectors++;
         if (rsp_valid !== m_rsp_v || rsp_rdata !== m_rsp_d) begin
            miscompares++;
            $display("FAIL rr_rsp[%0d] got %b/%h want %b/%h", i, rsp_valid, rsp_rdata, m_rsp_v, m_rsp_d);
         end
         commit();
      end
   endtask

   task automatic test_single_stream();
      int seen = 0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         if (i < 10) drive(2'b10, 2'b00, '0, AW'(i), '0, '0);
         else drive(2'b00, 2'b00, '0, '0, '0, '0);
         @(negedge clk);
         if (rsp_valid == 2'b10) seen++;
         if (i < 10) begin
            vectors++;
            if (req_ready !== 2'b10) begin
               miscompares++;
               $display("FAIL stream_ready[%0d] got %b want 10", i, req_ready);
            end
         end
         vectors++;
         if (rsp_rdata !== m_rsp_d) begin
            miscompares++;
            $display("FAIL stream_data[%0d] got %h want %h", i, rsp_rdata, m_rsp_d);
         end
         commit();
      end
      vectors++;
      if (seen != 10) begin
         miscompares++;
         $display("FAIL stream_count got %0d want 10", seen);
      end
   endtask

   task automatic test_drop_valid();
      logic [1:0] vs [3] = '{2'b01, 2'b11, 2'b10};
      logic [1:0] ws [3] = '{2'b01, 2'b01, 2'b10};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(vs[i], 2'b00, 6'h01, 6'h02, '0, '0);
         @(negedge clk);
         vectors++;
         if (req_ready !== ws[i]) begin
            miscompares++;
            $display("FAIL drop_valid[%0d] got %b want %b", i, req_ready, ws[i]);
         end
         commit();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(2'b01, 2'b00, 6'h05, 6'h00, '0, '0);
      @(negedge clk);
      commit();
      drive(2'b11, 2'b11, 6'h09, 6'h09, 8'hAA, 8'hBB);
      vectors++;
      if (rsp_valid !== 2'b01) begin
         miscompares++;
         $display("FAIL mid_pre got %b want 01", rsp_valid);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (rsp_valid !== 2'b00 || ram_we !== 1'b0 || req_ready !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_rst got rv=%b we=%b rdy=%b want 00 0 00", rsp_valid, ram_we, req_ready);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(2'b11, 2'b00, 6'h05, 6'h06, '0, '0);
      @(negedge clk);
      vectors++;
      if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_after got rdy=%b rv=%b want 01 00", req_ready, rsp_valid);
      end
      commit();
   endtask

   task automatic test_random();
      logic [1:0] g;
      int         gi;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               DW'($urandom), DW'($urandom));
         @(negedge clk);
         g  = exp_grant();
         gi = model_pick();
         vectors++;
         if (req_ready !== g) begin
            miscompares++;
            $display("FAIL rnd_ready[%0d] got %b want %b", i, req_ready, g);
         end
         vectors++;
         if (rsp_valid !== m_rsp_v || rsp_rdata !== m_rsp_d) begin
            miscompares++;
            $display("FAIL rnd_rsp[%0d] got %b/%h want %b/%h", i, rsp_valid, rsp_rdata, m_rsp_v, m_rsp_d);
         end
         vectors++;
         if (gi < 0) begin
            if (ram_we !== 1'b0 || ram_addr !== m_hold_a || ram_data !== m_hold_d) begin
               miscompares++;
               $display("FAIL rnd_hold[%0d] got %b/%h/%h want 0/%h/%h", i, ram_we, ram_addr, ram_data, m_hold_a, m_hold_d);
            end
         end else if (ram_we !== req_we[gi] || ram_addr !== addr_of(gi) ||
                      (req_we[gi] && ram_data !== data_of(gi))) begin
            miscompares++;
            $display("FAIL rnd_ram[%0d] got %b/%h/%h want %b/%h/%h", i, ram_we, ram_addr, ram_data, req_we[gi], addr_of(gi), data_of(gi));
         end
         commit();
      end
   endtask

`ifdef RAM_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive((i < 3) ? 2'b01 : 2'b10, 2'b11, AW'(i), AW'(i), '0, '0);
         @(negedge clk);
         commit();
      end
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      @(negedge clk);
      vectors++;
      if (grant_cnt0 !== 16'd3 || grant_cnt1 !== 16'd5) begin
         miscompares++;
         $display("FAIL stats_cnt got %0d/%0d want 3/5", grant_cnt0, grant_cnt1);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
         miscompares++;
         $display("FAIL stats_rst got %0d/%0d want 0/0", grant_cnt0, grant_cnt1);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram_mem[i] = '0;
         m_mem[i]   = '0;
      end
      ram_q = '0;
      model_reset();
      test_reset();
      test_write_read();
      test_fairness();
      test_single_stream();
      test_drop_valid();
      test_reset_mid();
      test_random();
`ifdef RAM_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
